pcpi_vector_issue: RTL and testbench
====================================

Name: pcpi_vector_issue

Overview:
- Sits between the picorv32 PCPI port and the vector unit. It is the upstream issue stage that feeds the vector unit's start/done handshake.
- Decodes custom-0 instructions, latches the instruction and operands, and pulses a one-cycle start to the vector unit.
- Holds the CPU with pcpi_wait until the unit reports done, then returns the result with pcpi_ready/pcpi_wr.
- A watchdog bounds every operation.

Parameters:
- OPCODE, 7'b0001011, major opcode accepted (custom-0).
- TIMEOUT_CYCLES, 1024, maximum cycles in BUSY before abort.
- ERR_RESULT, 32'hFFFF_FFFF, value returned to the CPU on timeout.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- pcpi_valid  in  1  CPU request valid.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1  in  32  operand 1.
- pcpi_rs2  in  32  operand 2.
- pcpi_wr  out  1  result writes rd.
- pcpi_rd  out  32  result data.
- pcpi_wait  out  1  stall CPU (suppresses the illegal-instruction timeout).
- pcpi_ready  out  1  result valid, one-cycle pulse.
- vu_start  out  1  one-cycle start pulse to the vector unit.
- vu_insn  out  32  latched instruction; funct=[6:0], vl=[31:7] downstream.
- vu_vs1  out  32  latched rs1.
- vu_vs2  out  32  latched rs2.
- vu_done  in  1  vector unit completion pulse.
- vu_result  in  32  vector unit result, valid with vu_done.
- busy  out  1  operation in flight.
- timeout_err  out  1  sticky; set on watchdog abort, cleared only by reset.

Behaviour:
- Clock and reset: single clock, clk. Asynchronous active-low reset, resetn.
- Reset values: all outputs 0; state IDLE; latches 0; counter 0.
- Match: pcpi_valid & pcpi_insn[6:0]==OPCODE. A non-matching request is ignored and all outputs stay 0, so the CPU raises illegal-instruction.
- IDLE:
  - On match, latch insn/rs1/rs2 and go to ISSUE.
  - pcpi_wait is registered high from the next cycle, i.e. 1-cycle latency, well inside the CPU's 16-cycle window.
- ISSUE: vu_start=1 for exactly one cycle; counter cleared; go to BUSY.
- BUSY:
  - Counter increments each cycle.
  - If vu_done arrives, capture vu_result into pcpi_rd and go to RESP.
  - If counter==TIMEOUT_CYCLES-1 without done: pcpi_rd=ERR_RESULT, set timeout_err, go to RESP.
- RESP:
  - pcpi_ready=1 for one cycle; pcpi_wait=0.
  - pcpi_wr = (insn[14:12]!=3'b111), where funct3 7 is store-class with no writeback.
  - Go to IDLE.
- Back-to-back: IDLE ignores pcpi_valid in the cycle immediately after RESP, because the CPU is still deasserting it. Minimum request-to-request spacing is therefore 2 cycles idle.
- vu_done in the same cycle as ISSUE: accepted, counts as done.
- vu_done in the timeout cycle: done wins and timeout_err is not set.
- vu_done outside BUSY: ignored.
- pcpi_valid drops during BUSY (CPU abort): go to DRAIN.
  - DRAIN waits for vu_done or timeout, with no pcpi_ready, then returns to IDLE.
  - busy stays high throughout.
- busy = state!=IDLE.
- vu_insn/vu_vs1/vu_vs2 hold stable from ISSUE until the next match.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no start is reissued.
- Counter width: clog2(TIMEOUT_CYCLES); it never wraps because the abort fires first.

Decomposition:
- Shared package vec_pkg:
  - state enum (IDLE, ISSUE, BUSY, RESP, DRAIN);
  - OPCODE_CUSTOM0;
  - FUNCT3_NOWB = 3'b111;
  - ERR_RESULT constant.
- One natural sub-module: vec_watchdog, a loadable counter with clear/enable and an expiry flag. Everything else stays in the top FSM.

Test Plan:
- Valid insn 32'h0000_000B, rs1=5, rs2=7; vu_done 4 cycles after vu_start with result 12 -> exactly one vu_start; pcpi_wait high from cycle 1; pcpi_ready+pcpi_wr pulse with pcpi_rd=12.
- Non-matching insn 32'h0000_0033 -> no vu_start; pcpi_wait/ready stay 0 for 20 cycles.
- TIMEOUT_CYCLES=16, vu_done never asserted -> pcpi_ready at BUSY cycle 16 with pcpi_rd=FFFF_FFFF; timeout_err=1 and stays set.
- funct3=7 (insn 32'h0000_700B) with done -> pcpi_ready=1, pcpi_wr=0.
- pcpi_valid dropped 2 cycles into BUSY, done 3 cycles later -> no pcpi_ready; busy falls the cycle after done; a following request is accepted normally.
- resetn asserted in BUSY, then released with a new request -> outputs 0 during reset; fresh single vu_start; correct result.

Source files
------------

// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared types and constants for the PCPI vector issue stage
package vec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP,
    DRAIN
  } state_t;

  localparam logic [6:0]  OPCODE_CUSTOM0 = 7'b0001011;
  localparam logic [2:0]  FUNCT3_NOWB    = 3'b111;
  localparam logic [31:0] ERR_RESULT_VAL = 32'hFFFF_FFFF;

endpackage

// File: rtl/vec_watchdog.sv
// rtl/vec_watchdog.sv - cycle counter with clear/enable that flags its last allowed cycle
module vec_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  // Holding at LAST keeps the counter from wrapping if the owner lingers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/pcpi_vector_issue.sv
// rtl/pcpi_vector_issue.sv - PCPI custom-0 decode and start/done issue stage for the vector unit
module pcpi_vector_issue
  import vec_pkg::*;
#(
  parameter logic [6:0]  OPCODE         = OPCODE_CUSTOM0,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RESULT     = ERR_RESULT_VAL
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        vu_start,
  output logic [31:0] vu_insn,
  output logic [31:0] vu_vs1,
  output logic [31:0] vu_vs2,
  input  logic        vu_done,
  input  logic [31:0] vu_result,
  output logic        busy,
  output logic        timeout_err
);

  state_t state;
  logic   cooldown;
  logic   match;
  logic   expired;
  logic   wd_clear;
  logic   wd_enable;
  logic   live_end;

  assign match     = pcpi_valid && (pcpi_insn[6:0] == OPCODE);
  assign wd_clear  = (state == ISSUE);
  assign wd_enable = (state == BUSY) || (state == DRAIN);

  // An operation the CPU is still waiting on finishes; done beats the watchdog.
  assign live_end = ((state == ISSUE) && vu_done) ||
                    ((state == BUSY) && pcpi_valid && (vu_done || expired));

  vec_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .resetn (resetn),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cooldown    <= 1'b0;
      pcpi_wr     <= 1'b0;
      pcpi_rd     <= '0;
      pcpi_wait   <= 1'b0;
      pcpi_ready  <= 1'b0;
      vu_start    <= 1'b0;
      vu_insn     <= '0;
      vu_vs1      <= '0;
      vu_vs2      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      vu_start   <= 1'b0;
      if (live_end) begin
        state      <= RESP;
        pcpi_ready <= 1'b1;
        pcpi_wr    <= (vu_insn[14:12] != FUNCT3_NOWB);
        pcpi_wait  <= 1'b0;
        pcpi_rd    <= vu_done ? vu_result : ERR_RESULT;
        if (!vu_done) timeout_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            // The CPU is still dropping pcpi_valid the cycle after a response.
            cooldown <= 1'b0;
            if (match && !cooldown) begin
              state     <= ISSUE;
              vu_insn   <= pcpi_insn;
              vu_vs1    <= pcpi_rs1;
              vu_vs2    <= pcpi_rs2;
              vu_start  <= 1'b1;
              pcpi_wait <= 1'b1;
              busy      <= 1'b1;
            end
          end
          ISSUE: state <= BUSY;
          BUSY, DRAIN: begin
            if ((state == DRAIN) || !pcpi_valid) begin
              pcpi_wait <= 1'b0;
              if (vu_done || expired) begin
                state <= IDLE;
                busy  <= 1'b0;
                if (!vu_done) timeout_err <= 1'b1;
              end else begin
                state <= DRAIN;
              end
            end
          end
          RESP: begin
            state    <= IDLE;
            cooldown <= 1'b1;
            busy     <= 1'b0;
            pcpi_rd  <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcpi_vector_issue.sv
// tb/tb_pcpi_vector_issue.sv - scoreboard bench for pcpi_vector_issue with a behavioural vector unit
module tb_pcpi_vector_issue;

  localparam int          TMO = 16;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic        clk;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        vu_start;
  logic [31:0] vu_insn;
  logic [31:0] vu_vs1;
  logic [31:0] vu_vs2;
  logic        vu_done;
  logic [31:0] vu_result;
  logic        busy;
  logic        timeout_err;

  int          total = 0;
  int          bad = 0;
  int          n_starts = 0;
  int          cur_lat = -1;
  int          vu_cd = -1;
  logic [31:0] cur_res = '0;
  logic        exp_terr = 1'b0;
  logic [32:0] exp_q[$];
  logic        any_out;

  assign any_out = |{pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, vu_start,
                     vu_insn, vu_vs1, vu_vs2, busy, timeout_err};

  pcpi_vector_issue #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready),
    .vu_start   (vu_start),
    .vu_insn    (vu_insn),
    .vu_vs1     (vu_vs1),
    .vu_vs2     (vu_vs2),
    .vu_done    (vu_done),
    .vu_result  (vu_result),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Vector unit: answers cur_lat cycles after the start cycle (-1 = never).
  initial begin
    vu_done   = 1'b0;
    vu_result = '0;
    forever begin
      @(negedge clk);
      vu_done = 1'b0;
      if (!resetn) begin
        vu_cd = -1;
      end else if (vu_start) begin
        n_starts++;
        vu_cd = cur_lat;
      end
      if (vu_cd == 0) begin
        vu_done   = 1'b1;
        vu_result = cur_res;
      end
      if (vu_cd >= 0) vu_cd--;
    end
  end

  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (resetn && pcpi_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got rd=%h expected no response", pcpi_rd);
        end else begin
          e = exp_q.pop_front();
          chk("sb_rd", pcpi_rd, e[31:0]);
          chk("sb_wr", 32'(pcpi_wr), 32'(e[32]));
        end
      end
    end
  end

  task automatic do_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] res);
    int   n;
    int   s0;
    logic hit;
    hit = (lat >= 0) && (lat <= TMO);
    exp_q.push_back({insn[14:12] != 3'b111, hit ? res : ERR});
    if (!hit) exp_terr = 1'b1;
    cur_lat = lat;
    cur_res = res;
    s0 = n_starts;
    @(posedge clk); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    @(negedge clk);
    chk("wait_before_issue", 32'(pcpi_wait), 0);
    @(negedge clk);
    chk("wait_latency", 32'(pcpi_wait), 1);
    chk("start_pulse", 32'(vu_start), 1);
    chk("busy_issue", 32'(busy), 1);
    chk("vu_insn", vu_insn, insn);
    chk("vu_vs1", vu_vs1, a);
    chk("vu_vs2", vu_vs2, b);
    n = 0;
    while (!pcpi_ready && n < 4 * TMO) begin
      @(negedge clk);
      n++;
    end
    chk("ready_cycle", 32'(n), 32'(hit ? lat + 1 : TMO + 1));
    chk("wait_at_ready", 32'(pcpi_wait), 0);
    chk("vu_insn_hold", vu_insn, insn);
    chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
    pcpi_insn  = $urandom();
    @(negedge clk);
    chk("ready_one_cycle", 32'({pcpi_ready, busy}), 0);
    chk("start_count", 32'(n_starts - s0), 1);
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  task automatic do_drop(input int lat, input logic [31:0] res);
    int s0;
    cur_lat = lat;
    cur_res = res;
    s0 = n_starts;
    @(posedge clk); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h0000_100B;
    pcpi_rs1   = 32'd9;
    pcpi_rs2   = 32'd10;
    @(negedge clk);
    @(negedge clk);
    chk("drop_start", 32'(vu_start), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
    for (int c = 3; c <= lat + 4; c++) begin
      @(negedge clk);
      chk("drop_busy", 32'(busy), 32'(c <= lat + 1));
    end
    chk("drop_wait", 32'(pcpi_wait), 0);
    chk("drop_terr", 32'(timeout_err), 32'(exp_terr));
    chk("drop_starts", 32'(n_starts - s0), 1);
    repeat (2) @(posedge clk);
  endtask

  initial begin : stim
    logic [31:0] r;
    int          lat;
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(any_out), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    do_op(32'h0000_000B, 32'd5, 32'd7, 4, 32'd12);

    begin : nomatch
      int s0;
      s0 = n_starts;
      @(posedge clk); #1;
      pcpi_valid = 1'b1;
      pcpi_insn  = 32'h0000_0033;
      repeat (20) begin
        @(negedge clk);
        chk("nomatch_quiet", 32'({pcpi_wait, pcpi_ready, vu_start, busy}), 0);
      end
      @(posedge clk); #1;
      pcpi_valid = 1'b0;
      chk("nomatch_starts", 32'(n_starts - s0), 0);
    end

    do_op(32'h0000_700B, 32'd3, 32'd4, 2, 32'h0000_ABCD);
    do_op(32'h0000_200B, 32'd1, 32'd1, 0, 32'h1111_2222);
    do_op(32'h0000_300B, 32'd2, 32'd2, TMO, 32'h3333_4444);
    do_op(32'h0000_000B, 32'd1, 32'd2, -1, 32'h0000_1234);
    do_op(32'h0000_400B, 32'd6, 32'd6, 3, 32'h5555_6666);
    do_op(32'h0000_500B, 32'd7, 32'd8, TMO + 1, 32'h7777_8888);
    do_drop(5, 32'h0000_0055);
    do_op(32'h0000_600B, 32'd8, 32'd9, 1, 32'h9999_AAAA);

    cur_lat = -1;
    @(posedge clk); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = 32'h0000_000B;
    repeat (4) @(posedge clk);
    #1;
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    @(negedge clk);
    chk("midreset_outs", 32'(any_out), 0);
    @(negedge clk);
    chk("midreset_hold", 32'(any_out), 0);
    @(posedge clk); #1;
    resetn   = 1'b1;
    exp_terr = 1'b0;
    do_op(32'h0000_000B, 32'd20, 32'd22, 5, 32'd42);

    for (int i = 0; i < 40; i++) begin
      r   = $urandom();
      lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TMO + 4));
      do_op({r[31:15], 3'($urandom_range(0, 7)), r[11:7], 7'b0001011},
            $urandom(), $urandom(), lat, $urandom());
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule
